// File: rtl/pong_pkg.sv
// Shared encodings and geometry for the pong game-level logic.
// State codes are fixed numerically because they are exported on the debug/HUD port.
package pong_pkg;

    localparam int SCORE_W = 4;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SERVE    = 3'd1;
    localparam logic [2:0] ST_RALLY    = 3'd2;
    localparam logic [2:0] ST_POINT    = 3'd3;
    localparam logic [2:0] ST_PAUSE    = 3'd4;
    localparam logic [2:0] ST_GAMEOVER = 3'd5;

    localparam int CENTER_X = 464;
    localparam int CENTER_Y = 275;

endpackage

// File: rtl/match_sequencer_btn_edge.sv
// Rising-edge detector for a debounced button level.
// A held button produces a single one-cycle pulse.
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic rise
);

    logic btn_q;

    always_ff @(posedge clk) begin
        if (rst) btn_q <= 1'b0;
        else     btn_q <= btn;
    end

    assign rise = btn & ~btn_q;

endmodule

// File: rtl/match_sequencer.sv
// Match-level sequencer: serve countdown, rally, point hold, pause and game over.
// Owns both scores, the serve direction and the winner flag; gates the ball mover.
module match_sequencer
    import pong_pkg::*;
#(
    parameter int WIN_SCORE   = 7,
    parameter int SERVE_TICKS = 120,
    parameter int POINT_TICKS = 60,
    parameter int CNT_W       = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               startBtn,
    input  logic               pauseBtn,
    input  logic               pointLeft,
    input  logic               pointRight,
    output logic               ballEn,
    output logic               ballCenter,
    output logic               serveDir,
    output logic [SCORE_W-1:0] scoreLeft,
    output logic [SCORE_W-1:0] scoreRight,
    output logic               gameOver,
    output logic               winner,
    output logic [2:0]         state
);

    localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);
    localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_TICKS - 1);
    localparam logic [CNT_W-1:0]   POINT_LAST = CNT_W'(POINT_TICKS - 1);

    logic             start_rise;
    logic             pause_rise;
    logic [2:0]       resume_q;
    logic [CNT_W-1:0] cnt;

    btn_edge u_start_edge (
        .clk  (clk),
        .rst  (rst),
        .btn  (startBtn),
        .rise (start_rise)
    );

    btn_edge u_pause_edge (
        .clk  (clk),
        .rst  (rst),
        .btn  (pauseBtn),
        .rise (pause_rise)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            resume_q   <= ST_IDLE;
            cnt        <= '0;
            scoreLeft  <= '0;
            scoreRight <= '0;
            serveDir   <= 1'b1;
            gameOver   <= 1'b0;
            winner     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_rise) begin
                        state <= ST_SERVE;
                        cnt   <= '0;
                    end
                end
                ST_SERVE: begin
                    // Counter is left untouched across PAUSE so the countdown resumes where it stopped.
                    if (pause_rise) begin
                        resume_q <= ST_SERVE;
                        state    <= ST_PAUSE;
                    end else if (tick) begin
                        if (cnt == SERVE_LAST) begin
                            state <= ST_RALLY;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                ST_RALLY: begin
                    if (pointLeft && pointRight) begin
                        state <= ST_POINT;
                        cnt   <= '0;
                    end else if (pointLeft) begin
                        if (scoreLeft != WIN) scoreLeft <= scoreLeft + SCORE_W'(1);
                        serveDir <= 1'b1;
                        state    <= ST_POINT;
                        cnt      <= '0;
                    end else if (pointRight) begin
                        if (scoreRight != WIN) scoreRight <= scoreRight + SCORE_W'(1);
                        serveDir <= 1'b0;
                        state    <= ST_POINT;
                        cnt      <= '0;
                    end else if (pause_rise) begin
                        resume_q <= ST_RALLY;
                        state    <= ST_PAUSE;
                    end
                end
                ST_POINT: begin
                    if (tick) begin
                        if (cnt == POINT_LAST) begin
                            cnt <= '0;
                            if (scoreLeft == WIN || scoreRight == WIN) begin
                                state    <= ST_GAMEOVER;
                                gameOver <= 1'b1;
                                winner   <= (scoreRight == WIN);
                            end else begin
                                state <= ST_SERVE;
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                ST_PAUSE: begin
                    if (pause_rise) state <= resume_q;
                end
                ST_GAMEOVER: begin
                    if (start_rise) begin
                        scoreLeft  <= '0;
                        scoreRight <= '0;
                        serveDir   <= 1'b1;
                        gameOver   <= 1'b0;
                        state      <= ST_SERVE;
                        cnt        <= '0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign ballEn     = tick & (state == ST_RALLY);
    assign ballCenter = ~((state == ST_RALLY) || (state == ST_PAUSE));

endmodule

// File: tb/tb_match_sequencer.sv
// Directed bench for match_sequencer with short serve/point timers and WIN_SCORE=3.
module tb_match_sequencer;

    localparam int WS = 3;
    localparam int ST = 4;
    localparam int PT = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       startBtn = 1'b0;
    logic       pauseBtn = 1'b0;
    logic       pointLeft = 1'b0;
    logic       pointRight = 1'b0;
    logic       ballEn;
    logic       ballCenter;
    logic       serveDir;
    logic [3:0] scoreLeft;
    logic [3:0] scoreRight;
    logic       gameOver;
    logic       winner;
    logic [2:0] state;

    int n_cmp = 0;
    int n_bad = 0;

    match_sequencer #(
        .WIN_SCORE   (WS),
        .SERVE_TICKS (ST),
        .POINT_TICKS (PT),
        .CNT_W       (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .startBtn   (startBtn),
        .pauseBtn   (pauseBtn),
        .pointLeft  (pointLeft),
        .pointRight (pointRight),
        .ballEn     (ballEn),
        .ballCenter (ballCenter),
        .serveDir   (serveDir),
        .scoreLeft  (scoreLeft),
        .scoreRight (scoreRight),
        .gameOver   (gameOver),
        .winner     (winner),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            cyc();
            tick = 1'b0;
        end
    endtask

    task automatic press_start();
        startBtn = 1'b1;
        cyc();
        startBtn = 1'b0;
    endtask

    task automatic press_pause();
        pauseBtn = 1'b1;
        cyc();
        pauseBtn = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        tick = 1'b1;
        cyc();
        cyc();
        #1;
        n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL reset_state got %0d want 0", state); end
        n_cmp++; if ({scoreLeft, scoreRight} !== 8'h00) begin n_bad++; $display("FAIL reset_scores got %0d/%0d want 0/0", scoreLeft, scoreRight); end
        n_cmp++; if (serveDir !== 1'b1) begin n_bad++; $display("FAIL reset_serveDir got %b want 1", serveDir); end
        n_cmp++; if (ballEn !== 1'b0) begin n_bad++; $display("FAIL reset_ballEn got %b want 0", ballEn); end
        n_cmp++; if (ballCenter !== 1'b1) begin n_bad++; $display("FAIL reset_ballCenter got %b want 1", ballCenter); end
        n_cmp++; if (gameOver !== 1'b0) begin n_bad++; $display("FAIL reset_gameOver got %b want 0", gameOver); end
        tick = 1'b0;
        rst  = 1'b0;
        cyc();
    endtask

    task automatic test_serve();
        press_start();
        n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL serve_enter got %0d want 1", state); end
        pointRight = 1'b1;
        cyc();
        pointRight = 1'b0;
        n_cmp++; if (scoreRight !== 4'd0) begin n_bad++; $display("FAIL serve_point_ignored got %0d want 0", scoreRight); end
        ticks(ST - 1);
        n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL serve_hold got %0d want 1", state); end
        tick = 1'b1;
        pointLeft = 1'b1;
        #1;
        n_cmp++; if (ballEn !== 1'b0) begin n_bad++; $display("FAIL serve_ballEn got %b want 0", ballEn); end
        cyc();
        tick = 1'b0;
        pointLeft = 1'b0;
        n_cmp++; if (state !== 3'd2) begin n_bad++; $display("FAIL serve_to_rally got %0d want 2", state); end
        cyc();
        n_cmp++; if (scoreLeft !== 4'd0) begin n_bad++; $display("FAIL entry_point_ignored got %0d want 0", scoreLeft); end
        n_cmp++; if (ballEn !== 1'b0) begin n_bad++; $display("FAIL rally_ballEn_notick got %b want 0", ballEn); end
        n_cmp++; if (ballCenter !== 1'b0) begin n_bad++; $display("FAIL rally_ballCenter got %b want 0", ballCenter); end
        tick = 1'b1;
        #1;
        n_cmp++; if (ballEn !== 1'b1) begin n_bad++; $display("FAIL rally_ballEn_tick got %b want 1", ballEn); end
        cyc();
        tick = 1'b0;
    endtask

    task automatic test_point();
        pointRight = 1'b1;
        cyc();
        pointRight = 1'b0;
        n_cmp++; if (scoreRight !== 4'd1) begin n_bad++; $display("FAIL point_scoreRight got %0d want 1", scoreRight); end
        n_cmp++; if (serveDir !== 1'b0) begin n_bad++; $display("FAIL point_serveDir got %b want 0", serveDir); end
        n_cmp++; if (state !== 3'd3) begin n_bad++; $display("FAIL point_state got %0d want 3", state); end
        ticks(PT - 1);
        n_cmp++; if (state !== 3'd3) begin n_bad++; $display("FAIL point_hold got %0d want 3", state); end
        ticks(1);
        n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL point_to_serve got %0d want 1", state); end
    endtask

    task automatic test_game_over();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        press_start();
        ticks(ST);
        for (int i = 0; i < WS; i++) begin
            pointLeft = 1'b1;
            cyc();
            pointLeft = 1'b0;
            n_cmp++; if (scoreLeft !== 4'(i + 1)) begin n_bad++; $display("FAIL go_scoreLeft%0d got %0d want %0d", i, scoreLeft, i + 1); end
            n_cmp++; if (serveDir !== 1'b1) begin n_bad++; $display("FAIL go_serveDir%0d got %b want 1", i, serveDir); end
            ticks(PT);
            if (i < WS - 1) begin
                n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL go_reserve%0d got %0d want 1", i, state); end
                ticks(ST);
            end
        end
        n_cmp++; if (state !== 3'd5) begin n_bad++; $display("FAIL go_state got %0d want 5", state); end
        n_cmp++; if (gameOver !== 1'b1) begin n_bad++; $display("FAIL go_flag got %b want 1", gameOver); end
        n_cmp++; if (winner !== 1'b0) begin n_bad++; $display("FAIL go_winner got %b want 0", winner); end
        n_cmp++; if (scoreRight !== 4'd0) begin n_bad++; $display("FAIL go_scoreRight got %0d want 0", scoreRight); end
        pauseBtn = 1'b1;
        cyc();
        pauseBtn = 1'b0;
        n_cmp++; if (state !== 3'd5) begin n_bad++; $display("FAIL go_pause_ignored got %0d want 5", state); end
        press_start();
        n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL go_restart got %0d want 1", state); end
        n_cmp++; if ({scoreLeft, scoreRight} !== 8'h00) begin n_bad++; $display("FAIL go_clear got %0d/%0d want 0/0", scoreLeft, scoreRight); end
        n_cmp++; if (gameOver !== 1'b0) begin n_bad++; $display("FAIL go_flag_clear got %b want 0", gameOver); end
    endtask

    task automatic test_pause();
        ticks(2);
        pauseBtn = 1'b1;
        cyc();
        n_cmp++; if (state !== 3'd4) begin n_bad++; $display("FAIL pause_serve got %0d want 4", state); end
        ticks(10);
        n_cmp++; if (state !== 3'd4) begin n_bad++; $display("FAIL pause_held got %0d want 4", state); end
        pauseBtn = 1'b0;
        cyc();
        press_pause();
        n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL resume_serve got %0d want 1", state); end
        ticks(1);
        n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL frozen_cnt_hold got %0d want 1", state); end
        ticks(1);
        n_cmp++; if (state !== 3'd2) begin n_bad++; $display("FAIL frozen_cnt_rally got %0d want 2", state); end
        press_pause();
        n_cmp++; if (state !== 3'd4) begin n_bad++; $display("FAIL pause_rally got %0d want 4", state); end
        n_cmp++; if (ballCenter !== 1'b0) begin n_bad++; $display("FAIL pause_ballCenter got %b want 0", ballCenter); end
        for (int i = 0; i < 10; i++) begin
            tick = 1'b1;
            pointLeft = (i == 3);
            pointRight = (i == 6);
            #1;
            if (i == 5) begin
                n_cmp++; if (ballEn !== 1'b0) begin n_bad++; $display("FAIL pause_ballEn got %b want 0", ballEn); end
            end
            cyc();
        end
        tick = 1'b0;
        pointLeft = 1'b0;
        pointRight = 1'b0;
        n_cmp++; if ({scoreLeft, scoreRight} !== 8'h00) begin n_bad++; $display("FAIL pause_scores got %0d/%0d want 0/0", scoreLeft, scoreRight); end
        press_pause();
        n_cmp++; if (state !== 3'd2) begin n_bad++; $display("FAIL resume_rally got %0d want 2", state); end
    endtask

    task automatic test_double_point_and_reset();
        pointRight = 1'b1;
        cyc();
        pointRight = 1'b0;
        ticks(PT + ST);
        n_cmp++; if (state !== 3'd2) begin n_bad++; $display("FAIL dbl_setup got %0d want 2", state); end
        pointLeft = 1'b1;
        pointRight = 1'b1;
        cyc();
        pointLeft = 1'b0;
        pointRight = 1'b0;
        n_cmp++; if (state !== 3'd3) begin n_bad++; $display("FAIL dbl_state got %0d want 3", state); end
        n_cmp++; if ({scoreLeft, scoreRight} !== 8'h01) begin n_bad++; $display("FAIL dbl_scores got %0d/%0d want 0/1", scoreLeft, scoreRight); end
        n_cmp++; if (serveDir !== 1'b0) begin n_bad++; $display("FAIL dbl_serveDir got %b want 0", serveDir); end
        ticks(1);
        rst = 1'b1;
        startBtn = 1'b1;
        cyc();
        rst = 1'b0;
        startBtn = 1'b0;
        n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL rst_point_state got %0d want 0", state); end
        n_cmp++; if ({scoreLeft, scoreRight} !== 8'h00) begin n_bad++; $display("FAIL rst_point_scores got %0d/%0d want 0/0", scoreLeft, scoreRight); end
        n_cmp++; if (serveDir !== 1'b1) begin n_bad++; $display("FAIL rst_point_serveDir got %b want 1", serveDir); end
    endtask

    initial begin
        test_reset();
        test_serve();
        test_point();
        test_game_over();
        test_pause();
        test_double_point_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
